// File: rtl/mac_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_sequencer_if
// Purpose  : Bundles the layer-controller handshake, the operand-memory read
//            port, the MAC control strobes and the result port of the
//            mac_sequencer into one interface.
// Ports    : master = the sequencer (drives addresses, MAC strobes, results)
//            slave  = its environment (top controller, operand RAMs, MAC)
// Revision : 1.0  initial release
// ============================================================================
interface mac_sequencer_if #(
    parameter int ADDR_W = 12
);
    // layer-level controller side
    logic              start;
    logic [1:0]        layer;
    logic [7:0]        in_w;
    logic [7:0]        out_w;
    logic [7:0]        out_h;
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] b_base;
    logic [ADDR_W-1:0] r_base;
    logic              busy;
    logic              done;
    // operand RAM / MAC side
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic              rd_en;
    logic              mac_en;
    logic              mac_clr;
    logic [1:0]        mac_layer;
    logic [31:0]       mac_out;
    // result port
    logic              res_valid;
    logic [ADDR_W-1:0] res_addr;
    logic [31:0]       res_data;

    modport master (
        input  start, layer, in_w, out_w, out_h, a_base, b_base, r_base, mac_out,
        output busy, done, a_addr, b_addr, rd_en, mac_en, mac_clr, mac_layer,
               res_valid, res_addr, res_data
    );

    modport slave (
        output start, layer, in_w, out_w, out_h, a_base, b_base, r_base, mac_out,
        input  busy, done, a_addr, b_addr, rd_en, mac_en, mac_clr, mac_layer,
               res_valid, res_addr, res_data
    );
endinterface
`default_nettype wire

// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_sequencer
// Purpose  : Control FSM that walks one MAC unit through a full conv or FC
//            layer pass: issues operand reads, drives MAC enable/clear,
//            captures each finished dot product and presents it with its
//            destination address.
// Ports    : clk   - clock
//            reset - asynchronous, active-high reset
//            sif   - mac_sequencer_if.master (config/start/busy/done,
//                    operand read addresses, MAC strobes, result port)
// Revision : 1.0  initial release
// ============================================================================
module mac_sequencer #(
    parameter int ADDR_W  = 12,
    parameter int KSIZE   = 5,
    parameter int FC_TAPS = 192
) (
    input  wire             clk,
    input  wire             reset,
    mac_sequencer_if.master sif
);

    localparam int CONV_TAPS = KSIZE * KSIZE;
    localparam int MAX_TAPS  = (FC_TAPS > CONV_TAPS) ? FC_TAPS : CONV_TAPS;
    localparam int TAP_W     = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;
    localparam int KX_W      = (KSIZE > 1) ? $clog2(KSIZE) : 1;

    localparam logic [TAP_W-1:0]  CONV_LAST = TAP_W'(CONV_TAPS - 1);
    localparam logic [TAP_W-1:0]  FC_LAST   = TAP_W'(FC_TAPS - 1);
    localparam logic [TAP_W-1:0]  TAP_ONE   = TAP_W'(1);
    localparam logic [KX_W-1:0]   KX_LAST   = KX_W'(KSIZE - 1);
    localparam logic [KX_W-1:0]   KX_ONE    = KX_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLR     = 3'd1,
        S_ISSUE   = 3'd2,
        S_TAIL    = 3'd3,
        S_DUMP    = 3'd4,
        S_CAPTURE = 3'd5,
        S_FIN     = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [TAP_W-1:0]  tap_q, tap_d;
    logic [KX_W-1:0]   kx_q, kx_d;
    logic [7:0]        ox_q, ox_d;
    logic [7:0]        oy_q, oy_d;
    logic              fc_q, fc_d;
    logic [7:0]        in_w_q, in_w_d;
    logic [7:0]        w_q, w_d;
    logic [7:0]        h_q, h_d;
    logic [ADDR_W-1:0] a_base_q, a_base_d;
    logic [ADDR_W-1:0] b_base_q, b_base_d;
    // out_row: a_base + oy*in_w          (start of the current output row)
    // out_ptr: a_base + oy*in_w + ox     (tap (0,0) of the current output)
    // tap_row: a_base + (oy+ky)*in_w + ox (tap (ky,0) of the current output)
    logic [ADDR_W-1:0] out_row_q, out_row_d;
    logic [ADDR_W-1:0] out_ptr_q, out_ptr_d;
    logic [ADDR_W-1:0] tap_row_q, tap_row_d;
    logic [ADDR_W-1:0] res_ptr_q, res_ptr_d;

    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [ADDR_W-1:0] b_addr_q, b_addr_d;
    logic              rd_en_q, rd_en_d;
    logic              mac_en_q, mac_en_d;
    logic              mac_clr_q, mac_clr_d;
    logic [1:0]        mac_layer_q, mac_layer_d;
    logic              res_valid_q, res_valid_d;
    logic [ADDR_W-1:0] res_addr_q, res_addr_d;
    logic [31:0]       res_data_q, res_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] w_in_w_ext;
    logic [TAP_W-1:0]  w_last_tap;
    logic              w_last_out;
    logic [ADDR_W-1:0] w_next_ptr;

    assign w_in_w_ext = ADDR_W'(in_w_q);
    assign w_last_tap = fc_q ? FC_LAST : CONV_LAST;
    // FC is handled as a 1-wide grid, so one test covers both layer kinds
    assign w_last_out = (ox_q == (w_q - 8'd1)) && (oy_q == (h_q - 8'd1));

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        kx_d        = kx_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        fc_d        = fc_q;
        in_w_d      = in_w_q;
        w_d         = w_q;
        h_d         = h_q;
        a_base_d    = a_base_q;
        b_base_d    = b_base_q;
        out_row_d   = out_row_q;
        out_ptr_d   = out_ptr_q;
        tap_row_d   = tap_row_q;
        res_ptr_d   = res_ptr_q;
        a_addr_d    = a_addr_q;
        b_addr_d    = b_addr_q;
        rd_en_d     = 1'b0;
        mac_en_d    = 1'b0;
        mac_clr_d   = 1'b0;
        mac_layer_d = mac_layer_q;
        res_valid_d = 1'b0;
        res_addr_d  = res_addr_q;
        res_data_d  = res_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        w_next_ptr  = out_ptr_q;

        case (state_q)
            S_IDLE: begin
                if (sif.start && (sif.layer != 2'd3)) begin
                    state_d     = S_CLR;
                    mac_clr_d   = 1'b1;
                    busy_d      = 1'b1;
                    fc_d        = (sif.layer == 2'd2);
                    mac_layer_d = sif.layer;
                    in_w_d      = sif.in_w;
                    w_d         = (sif.layer == 2'd2) ? 8'd1 : sif.out_w;
                    h_d         = sif.out_h;
                    a_base_d    = sif.a_base;
                    b_base_d    = sif.b_base;
                    out_row_d   = sif.a_base;
                    out_ptr_d   = sif.a_base;
                    tap_row_d   = sif.a_base;
                    res_ptr_d   = sif.r_base;
                    ox_d        = 8'd0;
                    oy_d        = 8'd0;
                end
            end

            S_CLR: begin
                if ((w_q == 8'd0) || (h_q == 8'd0)) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d  = S_ISSUE;
                    tap_d    = '0;
                    kx_d     = '0;
                    rd_en_d  = 1'b1;
                    a_addr_d = a_base_q;
                    b_addr_d = b_base_q;
                end
            end

            S_ISSUE: begin
                // Read data lags the address by a cycle, so the MAC is enabled
                // from tap 1 onward and once more in TAIL for the final tap.
                mac_en_d = 1'b1;
                if (tap_q == w_last_tap) begin
                    state_d = S_TAIL;
                end else begin
                    tap_d    = tap_q + TAP_ONE;
                    rd_en_d  = 1'b1;
                    b_addr_d = b_addr_q + ADDR_ONE;
                    if (fc_q) begin
                        a_addr_d = a_addr_q + ADDR_ONE;
                    end else if (kx_q == KX_LAST) begin
                        kx_d      = '0;
                        tap_row_d = tap_row_q + w_in_w_ext;
                        a_addr_d  = tap_row_q + w_in_w_ext;
                    end else begin
                        kx_d     = kx_q + KX_ONE;
                        a_addr_d = a_addr_q + ADDR_ONE;
                    end
                end
            end

            S_TAIL: begin
                state_d  = S_DUMP;
                mac_en_d = 1'b1;
            end

            // the enabled DUMP cycle makes the MAC publish its sum on mac_out
            S_DUMP: begin
                state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                res_data_d  = sif.mac_out;
                res_addr_d  = res_ptr_q;
                res_valid_d = 1'b1;
                res_ptr_d   = res_ptr_q + ADDR_ONE;
                if (w_last_out) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_ISSUE;
                    tap_d   = '0;
                    kx_d    = '0;
                    rd_en_d = 1'b1;
                    if (fc_q) begin
                        // FC weight rows are contiguous: j*FC_TAPS + k just keeps counting
                        oy_d     = oy_q + 8'd1;
                        a_addr_d = a_base_q;
                        b_addr_d = b_addr_q + ADDR_ONE;
                    end else begin
                        b_addr_d = b_base_q;
                        if (ox_q == (w_q - 8'd1)) begin
                            ox_d       = 8'd0;
                            oy_d       = oy_q + 8'd1;
                            out_row_d  = out_row_q + w_in_w_ext;
                            w_next_ptr = out_row_q + w_in_w_ext;
                        end else begin
                            ox_d       = ox_q + 8'd1;
                            w_next_ptr = out_ptr_q + ADDR_ONE;
                        end
                        out_ptr_d = w_next_ptr;
                        tap_row_d = w_next_ptr;
                        a_addr_d  = w_next_ptr;
                    end
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tap_q       <= '0;
            kx_q        <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            fc_q        <= 1'b0;
            in_w_q      <= '0;
            w_q         <= '0;
            h_q         <= '0;
            a_base_q    <= '0;
            b_base_q    <= '0;
            out_row_q   <= '0;
            out_ptr_q   <= '0;
            tap_row_q   <= '0;
            res_ptr_q   <= '0;
            a_addr_q    <= '0;
            b_addr_q    <= '0;
            rd_en_q     <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b0;
            mac_layer_q <= '0;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            kx_q        <= kx_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            fc_q        <= fc_d;
            in_w_q      <= in_w_d;
            w_q         <= w_d;
            h_q         <= h_d;
            a_base_q    <= a_base_d;
            b_base_q    <= b_base_d;
            out_row_q   <= out_row_d;
            out_ptr_q   <= out_ptr_d;
            tap_row_q   <= tap_row_d;
            res_ptr_q   <= res_ptr_d;
            a_addr_q    <= a_addr_d;
            b_addr_q    <= b_addr_d;
            rd_en_q     <= rd_en_d;
            mac_en_q    <= mac_en_d;
            mac_clr_q   <= mac_clr_d;
            mac_layer_q <= mac_layer_d;
            res_valid_q <= res_valid_d;
            res_addr_q  <= res_addr_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sif.a_addr    = a_addr_q;
    assign sif.b_addr    = b_addr_q;
    assign sif.rd_en     = rd_en_q;
    assign sif.mac_en    = mac_en_q;
    assign sif.mac_clr   = mac_clr_q;
    assign sif.mac_layer = mac_layer_q;
    assign sif.res_valid = res_valid_q;
    assign sif.res_addr  = res_addr_q;
    assign sif.res_data  = res_data_q;
    assign sif.busy      = busy_q;
    assign sif.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mac_sequencer
// Purpose  : Self-checking bench for mac_sequencer. Models the operand RAMs
//            (1-cycle read) and the MAC, predicts every result from the
//            addressing equations and compares through a scoreboard.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_mac_sequencer;

    localparam int ADDR_W = 12;
    localparam int AMASK  = (1 << ADDR_W) - 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_sequencer_if #(.ADDR_W(ADDR_W)) sif ();

    mac_sequencer #(.ADDR_W(ADDR_W), .KSIZE(5), .FC_TAPS(192)) u_dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    // operand RAMs and MAC model
    logic signed [31:0] mem_a [0:4095];
    logic signed [31:0] mem_b [0:4095];
    logic signed [31:0] a_rd, b_rd, acc, mac_out_r;
    int                 mac_cnt;

    assign sif.mac_out = mac_out_r;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rd <= '0; b_rd <= '0; acc <= '0; mac_out_r <= '0; mac_cnt <= 0;
        end else begin
            if (sif.rd_en) begin
                a_rd <= mem_a[sif.a_addr];
                b_rd <= mem_b[sif.b_addr];
            end
            if (sif.mac_clr) begin
                acc <= '0; mac_cnt <= 0;
            end else if (sif.mac_en) begin
                if (mac_cnt < ((sif.mac_layer == 2'd2) ? 192 : 25)) begin
                    acc     <= acc + a_rd * b_rd;
                    mac_cnt <= mac_cnt + 1;
                end else begin
                    mac_out_r <= acc; acc <= '0; mac_cnt <= 0;
                end
            end
        end
    end

    int   total, bad;
    int   cyc, done_cnt, rv_cnt, rd_cnt, clr_cyc, done_cyc, st_cyc, men_run;
    logic prev_rd;
    res_t sb[$];
    logic [ADDR_W-1:0] a_log[$];
    logic [ADDR_W-1:0] b_start[$];
    int   men_q[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] outs_vec();
        return {sif.a_addr, sif.b_addr, sif.rd_en, sif.mac_en, sif.mac_clr, sif.mac_layer,
                sif.res_valid, sif.res_addr, sif.res_data, sif.busy, sif.done};
    endfunction

    // monitor: samples 1 ns after each rising edge
    initial begin
        res_t e;
        cyc = 0; done_cnt = 0; rv_cnt = 0; rd_cnt = 0; clr_cyc = 0; done_cyc = 0;
        men_run = 0; prev_rd = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sif.mac_clr) begin clr_cyc = cyc; men_run = 0; end
            if (sif.mac_en) men_run++;
            if (sif.rd_en) begin
                rd_cnt++;
                a_log.push_back(sif.a_addr);
                if (!prev_rd) b_start.push_back(sif.b_addr);
            end
            prev_rd = sif.rd_en;
            if (sif.res_valid) begin
                rv_cnt++;
                men_q.push_back(men_run);
                men_run = 0;
                if (sb.size() == 0) begin
                    chk("res_unexpected", 128'(sif.res_addr), 128'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("res_addr", 128'(sif.res_addr), 128'(e.addr));
                    chk("res_data", 128'(sif.res_data), 128'(e.data));
                end
            end
            if (sif.done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    task automatic fill(input int mode);
        for (int i = 0; i < 4096; i++) begin
            case (mode)
                0:       begin mem_a[i] = 32'((i * 7 + 3) % 23 - 11); mem_b[i] = 32'((i * 5) % 13 - 6); end
                1:       begin mem_a[i] = 32'sd1;  mem_b[i] = 32'sd2; end
                default: begin mem_a[i] = -32'sd3; mem_b[i] = 32'sd7; end
            endcase
        end
    endtask

    task automatic push_conv(input int iw, input int ow, input int oh, input int ab, input int bb, input int rb);
        res_t e;
        logic signed [31:0] s;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++) begin
                s = 0;
                for (int ky = 0; ky < 5; ky++)
                    for (int kx = 0; kx < 5; kx++)
                        s += mem_a[(ab + (oy + ky) * iw + ox + kx) & AMASK] * mem_b[(bb + ky * 5 + kx) & AMASK];
                e.addr = ADDR_W'(rb + oy * ow + ox);
                e.data = s;
                sb.push_back(e);
            end
    endtask

    task automatic push_fc(input int oh, input int ab, input int bb, input int rb);
        res_t e;
        logic signed [31:0] s;
        for (int j = 0; j < oh; j++) begin
            s = 0;
            for (int k = 0; k < 192; k++)
                s += mem_a[(ab + k) & AMASK] * mem_b[(bb + j * 192 + k) & AMASK];
            e.addr = ADDR_W'(rb + j);
            e.data = s;
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start(input logic [1:0] ly, input logic [7:0] iw, input logic [7:0] ow,
                               input logic [7:0] oh, input logic [11:0] ab, input logic [11:0] bb,
                               input logic [11:0] rb);
        @(negedge clk);
        sif.start = 1'b1; sif.layer = ly; sif.in_w = iw; sif.out_w = ow; sif.out_h = oh;
        sif.a_base = ab; sif.b_base = bb; sif.r_base = rb;
        st_cyc = cyc;
        @(negedge clk);
        // config is don't-care once latched; scramble it
        sif.start = 1'b0; sif.layer = 2'($urandom); sif.in_w = 8'($urandom);
        sif.out_w = 8'($urandom); sif.out_h = 8'($urandom);
        sif.a_base = 12'($urandom); sif.b_base = 12'($urandom); sif.r_base = 12'($urandom);
    endtask

    task automatic wait_done(input int maxc);
        int d0;
        bit seen;
        d0 = done_cnt; seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (done_cnt != d0) seen = 1;
        end
        if (!seen) chk("done_timeout", 128'(0), 128'(1));
    endtask

    initial begin
        int d0, r0, rv0;
        bit seen;
        total = 0; bad = 0;
        sif.start = 1'b0; sif.layer = 2'd0; sif.in_w = '0; sif.out_w = '0; sif.out_h = '0;
        sif.a_base = '0; sif.b_base = '0; sif.r_base = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs_vec(), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("idle_outs", outs_vec(), 128'(0));

        // conv 2x2, in_w 6
        fill(0);
        a_log.delete(); men_q.delete(); rv0 = rv_cnt;
        push_conv(6, 2, 2, 'h100, 'h200, 'h300);
        pulse_start(2'd0, 8'd6, 8'd2, 8'd2, 12'h100, 12'h200, 12'h300);
        wait_done(400);
        chk("conv_nres", 128'(rv_cnt - rv0), 128'(4));
        chk("conv_done_lat", 128'(done_cyc - clr_cyc), 128'(4 * 28 + 1));
        for (int i = 0; i < 25; i++)
            chk("conv_a_addr", 128'(a_log[i]), 128'('h100 + (i / 5) * 6 + (i % 5)));
        chk("conv_men", 128'(men_q[0]), 128'(26));
        chk("conv_busy_end", 128'(sif.busy), 128'(0));

        // FC, 3 outputs, A=1 B=2
        fill(1);
        b_start.delete(); men_q.delete();
        push_fc(3, 'h040, 'h000, 'h500);
        pulse_start(2'd2, 8'd9, 8'd9, 8'd3, 12'h040, 12'h000, 12'h500);
        wait_done(1000);
        for (int j = 0; j < 3; j++) chk("fc_men", 128'(men_q[j]), 128'(193));
        chk("fc_b1_start", 128'(b_start[1]), 128'(192));
        chk("fc_b2_start", 128'(b_start[2]), 128'(384));
        chk("fc_res_data", 128'(sif.res_data), 128'(384));

        // signed: -3 * 7 over 25 taps
        fill(2);
        push_conv(5, 1, 1, 'h010, 'h020, 'h030);
        pulse_start(2'd1, 8'd5, 8'd1, 8'd1, 12'h010, 12'h020, 12'h030);
        wait_done(100);
        chk("signed_res", 128'(sif.res_data), 128'(32'hFFFF_FDF3));

        // illegal layer, then start during busy; also address wrap
        fill(0);
        r0 = rd_cnt; d0 = done_cnt;
        pulse_start(2'd3, 8'd6, 8'd2, 8'd2, 12'h100, 12'h200, 12'h300);
        repeat (10) @(negedge clk);
        chk("illegal_busy", 128'(sif.busy), 128'(0));
        chk("illegal_rd", 128'(rd_cnt - r0), 128'(0));
        rv0 = rv_cnt;
        push_conv(8, 3, 2, 'hFF0, 'hFFE, 'hFFD);
        pulse_start(2'd0, 8'd8, 8'd3, 8'd2, 12'hFF0, 12'hFFE, 12'hFFD);
        repeat (20) @(negedge clk);
        pulse_start(2'd2, 8'd4, 8'd4, 8'd9, 12'h000, 12'h000, 12'h000);
        wait_done(600);
        repeat (60) @(negedge clk);
        chk("busy_ign_done", 128'(done_cnt - d0), 128'(1));
        chk("busy_ign_nres", 128'(rv_cnt - rv0), 128'(6));
        chk("busy_ign_idle", 128'(sif.busy), 128'(0));

        // reset during output 1's ISSUE
        rv0 = rv_cnt;
        push_conv(6, 2, 2, 'h100, 'h200, 'h300);
        pulse_start(2'd0, 8'd6, 8'd2, 8'd2, 12'h100, 12'h200, 12'h300);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (rv_cnt != rv0) seen = 1;
        end
        if (!seen) chk("rst_wait_timeout", 128'(0), 128'(1));
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #2;
        chk("rst_mid_outs", outs_vec(), 128'(0));
        chk("rst_mid_pending", 128'(sb.size()), 128'(3));
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        rv0 = rv_cnt;
        repeat (40) @(negedge clk);
        chk("rst_no_res", 128'(rv_cnt - rv0), 128'(0));
        push_conv(7, 3, 2, 'h080, 'h3C0, 'h600);
        pulse_start(2'd0, 8'd7, 8'd3, 8'd2, 12'h080, 12'h3C0, 12'h600);
        wait_done(400);
        chk("rst_rerun_nres", 128'(rv_cnt - rv0), 128'(6));

        // zero-size passes
        r0 = rd_cnt; rv0 = rv_cnt;
        pulse_start(2'd2, 8'd5, 8'd5, 8'd0, 12'h000, 12'h000, 12'h000);
        wait_done(20);
        chk("fc0_done_lat", 128'(done_cyc - st_cyc), 128'(2));
        pulse_start(2'd0, 8'd5, 8'd0, 8'd4, 12'h000, 12'h000, 12'h000);
        wait_done(20);
        chk("conv0_done_lat", 128'(done_cyc - st_cyc), 128'(2));
        chk("zero_rd", 128'(rd_cnt - r0), 128'(0));
        chk("zero_res", 128'(rv_cnt - rv0), 128'(0));

        repeat (5) @(negedge clk);
        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Control FSM that drives one MAC unit through a full conv or FC layer pass.
- Generates operand-memory read addresses and the MAC enable/clear/layer strobes, then captures each finished dot product and presents it with its destination address.
- Sits between the layer-level top controller (start/config/done) and the MAC plus its operand RAMs (A = activations, B = weights, 1-cycle synchronous read).

Parameters:
ADDR_W, 12, width of all memory addresses
KSIZE, 5, conv kernel side; conv taps N = KSIZE*KSIZE = 25
FC_TAPS, 192, taps per FC output

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a pass when idle
layer  in  2  0/1 = conv, 2 = FC, 3 = illegal
in_w  in  8  conv input row width (words)
out_w  in  8  conv output width; ignored for FC
out_h  in  8  conv output height; FC: number of outputs
a_base  in  ADDR_W  activation base address
b_base  in  ADDR_W  weight base address
r_base  in  ADDR_W  result base address
a_addr  out  ADDR_W  activation read address
b_addr  out  ADDR_W  weight read address
rd_en  out  1  operand read strobe
mac_en  out  1  MAC enable
mac_clr  out  1  MAC reset pulse
mac_layer  out  2  layer code to MAC, latched at start
mac_out  in  32  signed MAC result
res_valid  out  1  one-cycle result strobe
res_addr  out  ADDR_W  result write address
res_data  out  32  captured signed result
busy  out  1  high from accepted start to done
done  out  1  one-cycle pulse after last result

Behaviour:
- Reset: state IDLE. All outputs 0, including addresses, res_data, mac_layer, done and busy.
- MAC contract: on each enabled cycle, the MAC accumulates A*B while its internal count < N. On enabled cycle N+1 it registers the sum on mac_out and clears itself. mac_out holds its value while disabled.
- Start handling:
  - In IDLE, start with layer != 3 latches all config inputs and asserts mac_clr for 1 cycle (state CLR).
  - start with layer = 3 is ignored.
  - start while busy is ignored.
  - Config inputs are don't-care after they are latched.
- States: IDLE -> CLR -> ISSUE -> TAIL -> DUMP -> CAPTURE -> (ISSUE | FIN) -> IDLE.
  - ISSUE: N cycles, tap k = 0..N-1. rd_en = 1 and addresses are valid in the same cycle.
  - mac_en = 1 in ISSUE cycles k = 1..N-1, in TAIL (last tap accumulates), and in DUMP.
  - mac_en = 0 in ISSUE k = 0, in CAPTURE, in CLR, and in IDLE.
  - Per-output period is exactly N+3 cycles. Outputs are not overlapped.
- CAPTURE: res_data <= mac_out, res_addr <= r_base + out_idx, res_valid = 1 for 1 cycle (registered, asserted during the cycle after CAPTURE). The next output's ISSUE begins in that same cycle.
- Conv addressing, outputs (oy, ox) in row-major order, taps (ky, kx) row-major:
  - a_addr = a_base + (oy+ky)*in_w + ox + kx.
  - b_addr = b_base + ky*KSIZE + kx (the kernel is shared by all outputs).
  - Total outputs = out_w*out_h.
- FC addressing, output j = 0..out_h-1, tap k:
  - a_addr = a_base + k.
  - b_addr = b_base + j*FC_TAPS + k.
- Implement addressing with running row and output pointers (adders only, no multipliers).
- Address arithmetic wraps modulo 2^ADDR_W with no error flag.
- Pass completion: after the last CAPTURE -> FIN. done = 1 for 1 cycle, busy drops in the same cycle, then IDLE.
- Zero-size pass (out_w = 0 or out_h = 0 for conv; out_h = 0 for FC): CLR -> FIN directly. No reads and no res_valid.
- Async reset mid-pass: immediate return to IDLE with all outputs 0. A partial result is never emitted.

Test Plan:
- Conv, in_w=6, out_w=2, out_h=2, a_base=0x100, b_base=0x200, r_base=0x300:
  - 4 res_valid pulses with res_addr 0x300..0x303.
  - First-output a_addr sequence 0x100..0x104, 0x106..0x10A, ..., 0x118..0x11C.
  - done 4*28+1 cycles after CLR.
- FC, out_h=3, b_base=0x000, A=all 1, B=all 2:
  - each res_data = 384.
  - b_addr for output 2 starts at 384.
  - mac_en high exactly 193 cycles per output.
- Signed check: A=-3, B=7 for all 25 conv taps -> res_data = -525 (0xFFFFFDF3).
- start pulsed during busy and start with layer=3 -> no config change and no extra pass; a single done pulse.
- Reset asserted in ISSUE of output 1 -> all outputs 0 next edge, no res_valid. A new start runs a full pass with correct results.
- out_h=0, FC -> done 2 cycles after start, rd_en never high.
